// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register placed directly after the 16x16 register file.
// It captures the register read data (with same-cycle write-back bypass)
// and the decoded fields for the execute stage. It also detects load-use
// hazards, inserts one bubble per load-use pair, honours downstream
// backpressure and branch flush, and counts inserted bubbles.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   id_valid / id_ready ID handshake (id_ready is combinational)
//   rs1, rs2, rd        source / destination register addresses
//   reg1, reg2          register file read data for rs1 / rs2 (same cycle)
//   imm, ctrl           sign-extended immediate, decoded control bundle
//                       (ctrl[0] = reg_write, ctrl[1] = mem_read)
//   wb_en, wb_rd,       write-back port, identical to the register file
//   wb_data             write port; used for the same-cycle bypass
//   flush               kills the ID instruction and the EX slot
//   ex_ready / ex_valid EX handshake
//   ex_rs1, ex_rs2, ex_rd, ex_a, ex_b, ex_imm, ex_ctrl
//                       registered fields for the execute stage
//   hazard              a load-use bubble is being requested (combinational)
//   stall_count         saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [DATA_W-1:0] imm,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [ADDR_W-1:0] ex_rs1,
  output logic [ADDR_W-1:0] ex_rs2,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hazard,
  output logic [CNT_W-1:0]  stall_count
);

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic              vld_p1;
  logic [ADDR_W-1:0] rs1_p1, rs2_p1, rd_p1;
  logic [DATA_W-1:0] a_p1, b_p1, imm_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [CNT_W-1:0]  stall_cnt_p1;

  logic [DATA_W-1:0] a_p0, b_p0;
  logic              hold_p0;
  logic              hazard_p0;

  // ---- Stage p0: ID side (bypass, hazard detect, handshake) ----
  // The register file does not forward its own write, so a same-cycle
  // write-back to a source register is picked up here, address 0 included.
  always_comb begin
    a_p0 = (wb_en && (wb_rd == rs1)) ? wb_data : reg1;
    b_p0 = (wb_en && (wb_rd == rs2)) ? wb_data : reg2;
  end

  assign hold_p0   = vld_p1 && !ex_ready;
  assign hazard_p0 = vld_p1 && ctrl_p1[1] && id_valid &&
                     ((rd_p1 == rs1) || (rd_p1 == rs2));

  // A flush always consumes the ID instruction, even while EX is stalled.
  assign id_ready = !reset && (flush || (!hold_p0 && !hazard_p0));
  assign hazard   = hazard_p0;

  // ---- Stage p1: EX-facing register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      a_p1         <= '0;
      b_p1         <= '0;
      imm_p1       <= '0;
      ctrl_p1      <= '0;
      stall_cnt_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (hold_p0) begin
      // EX not consuming: everything stays put, a pending hazard is not counted.
      vld_p1 <= vld_p1;
    end else if (hazard_p0) begin
      // One bubble lets the load leave EX; the dependent instruction waits in ID.
      vld_p1       <= 1'b0;
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end else if (id_valid) begin
      vld_p1  <= 1'b1;
      rs1_p1  <= rs1;
      rs2_p1  <= rs2;
      rd_p1   <= rd;
      a_p1    <= a_p0;
      b_p1    <= b_p0;
      imm_p1  <= imm;
      ctrl_p1 <= ctrl;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign ex_valid    = vld_p1;
  assign ex_rs1      = rs1_p1;
  assign ex_rs2      = rs2_p1;
  assign ex_rd       = rd_p1;
  assign ex_a        = a_p1;
  assign ex_b        = b_p1;
  assign ex_imm      = imm_p1;
  assign ex_ctrl     = ctrl_p1;
  assign stall_count = stall_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [3:0]  rs1, rs2, rd, wb_rd;
  logic [15:0] reg1, reg2, imm, wb_data;
  logic [7:0]  ctrl;
  logic        wb_en, flush, ex_ready;

  logic        id_ready, ex_valid, hazard;
  logic [3:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_a, ex_b, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [15:0] stall_count;

  // Second instance with a narrow counter so saturation is reachable quickly.
  logic        s_id_ready, s_ex_valid, s_hazard;
  logic [3:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [15:0] s_ex_a, s_ex_b, s_ex_imm;
  logic [7:0]  s_ex_ctrl;
  logic [3:0]  s_stall_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [3:0]  rd;
    logic [7:0]  ctrl;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg1(reg1), .reg2(reg2), .imm(imm),
    .ctrl(ctrl), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_a(ex_a),
    .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .hazard(hazard),
    .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(s_id_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg1(reg1), .reg2(reg2), .imm(imm),
    .ctrl(ctrl), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(s_ex_valid),
    .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_a(s_ex_a),
    .ex_b(s_ex_b), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl), .hazard(s_hazard),
    .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] d,
                       input logic [15:0] v1, input logic [15:0] v2,
                       input logic [15:0] im, input logic [7:0] c);
    id_valid = 1'b1;
    rs1 = r1; rs2 = r2; rd = d;
    reg1 = v1; reg2 = v2; imm = im; ctrl = c;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] im, input logic [3:0] d, input logic [7:0] c);
    exp_t e;
    e.a = a; e.b = b; e.imm = im; e.rd = d; e.ctrl = c;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(ex_valid), 32'd1);
      chk({tag, "_a"},     32'(ex_a),     32'(e.a));
      chk({tag, "_b"},     32'(ex_b),     32'(e.b));
      chk({tag, "_imm"},   32'(ex_imm),   32'(e.imm));
      chk({tag, "_rd"},    32'(ex_rd),    32'(e.rd));
      chk({tag, "_ctrl"},  32'(ex_ctrl),  32'(e.ctrl));
    end
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
    reg1 = '0; reg2 = '0; imm = '0; ctrl = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;

    // Reset state
    repeat (10) tick();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_a", 32'(ex_a), 32'd0);
    chk("rst_ex_b", 32'(ex_b), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd0);
    reset = 1'b0;
    settle();
    chk("post_rst_id_ready", 32'(id_ready), 32'd1);

    // Plain capture
    drive(4'd3, 4'd4, 4'd1, 16'h1234, 16'h00FF, 16'h0007, 8'h01);
    push(16'h1234, 16'h00FF, 16'h0007, 4'd1, 8'h01);
    tick();
    check_out("plain");
    chk("plain_ex_rs1", 32'(ex_rs1), 32'd3);
    chk("plain_ex_rs2", 32'(ex_rs2), 32'd4);

    // Write-back bypass onto rs2
    drive(4'd3, 4'd4, 4'd2, 16'h1234, 16'h00FF, 16'h0008, 8'h01);
    wb_en = 1'b1; wb_rd = 4'd4; wb_data = 16'hBEEF;
    push(16'h1234, 16'hBEEF, 16'h0008, 4'd2, 8'h01);
    tick();
    check_out("bypass");

    // Bypass on address 0 for rs1
    drive(4'd0, 4'd4, 4'd6, 16'h0000, 16'h0044, 16'h0009, 8'h00);
    wb_rd = 4'd0; wb_data = 16'hC0DE;
    push(16'hC0DE, 16'h0044, 16'h0009, 4'd6, 8'h00);
    tick();
    check_out("bypass_r0");
    wb_en = 1'b0;

    // Load-use: load rd=5 then add rs1=5
    drive(4'd1, 4'd2, 4'd5, 16'h0010, 16'h0020, 16'h0004, 8'h02);
    push(16'h0010, 16'h0020, 16'h0004, 4'd5, 8'h02);
    tick();
    check_out("load");
    drive(4'd5, 4'd6, 4'd7, 16'h1111, 16'h2222, 16'h0001, 8'h01);
    settle();
    chk("lu_hazard", 32'(hazard), 32'd1);
    chk("lu_id_ready", 32'(id_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_stall", 32'(stall_count), 32'd1);
    chk("lu_hazard_off", 32'(hazard), 32'd0);
    chk("lu_id_ready_on", 32'(id_ready), 32'd1);
    push(16'h1111, 16'h2222, 16'h0001, 4'd7, 8'h01);
    tick();
    check_out("lu_add");

    // Backpressure for 3 cycles with a new instruction waiting
    ex_ready = 1'b0;
    drive(4'd8, 4'd9, 4'd10, 16'hAAAA, 16'h5555, 16'h0002, 8'h00);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_id_ready", 32'(id_ready), 32'd0);
      tick();
      chk("hold_ex_valid", 32'(ex_valid), 32'd1);
      chk("hold_ex_a", 32'(ex_a), 32'h1111);
      chk("hold_ex_rd", 32'(ex_rd), 32'd7);
    end
    ex_ready = 1'b1;
    settle();
    chk("release_id_ready", 32'(id_ready), 32'd1);
    push(16'hAAAA, 16'h5555, 16'h0002, 4'd10, 8'h00);
    tick();
    check_out("release");

    // Hazard during hold: no bubble counted; then flush
    drive(4'd1, 4'd2, 4'd3, 16'h0303, 16'h0404, 16'h0003, 8'h02);
    push(16'h0303, 16'h0404, 16'h0003, 4'd3, 8'h02);
    tick();
    check_out("load2");
    ex_ready = 1'b0;
    drive(4'd3, 4'd0, 4'd4, 16'h0001, 16'h0002, 16'h0000, 8'h01);
    settle();
    chk("hh_hazard", 32'(hazard), 32'd1);
    chk("hh_id_ready", 32'(id_ready), 32'd0);
    tick();
    chk("hh_stall", 32'(stall_count), 32'd1);
    chk("hh_ex_valid", 32'(ex_valid), 32'd1);
    chk("hh_ex_rd", 32'(ex_rd), 32'd3);
    flush = 1'b1;
    settle();
    chk("flush_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    chk("flush_stall", 32'(stall_count), 32'd1);
    flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0;
    tick();
    chk("idle_ex_valid", 32'(ex_valid), 32'd0);

    // Back-to-back self-dependent loads: a bubble every other cycle
    drive(4'd5, 4'd0, 4'd5, 16'h0000, 16'h0000, 16'h0000, 8'h02);
    repeat (40) tick();
    chk("chain_stall", 32'(stall_count), 32'd21);
    chk("sat_stall", 32'(s_stall_count), 32'hF);
    chk("chain_ex_valid", 32'(ex_valid), 32'd0);
    tick();
    chk("chain_hazard", 32'(hazard), 32'd1);
    chk("sat_hold_max", 32'(s_ex_valid), 32'd1);
    tick();
    chk("sat_stays", 32'(s_stall_count), 32'hF);

    // Reset mid-stall
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_stall", 32'(stall_count), 32'd0);
    chk("mid_rst_sat_stall", 32'(s_stall_count), 32'd0);
    chk("mid_rst_id_ready", 32'(id_ready), 32'd0);
    chk("mid_rst_hazard", 32'(hazard), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
